// File: rtl/serial_to_parallel_sync_if.sv
// Receive-lane deserialiser bundle: serial bit in, recovered word/valid/lock out.
// WORD_CNT (and its width CNT_W) exist only when S2P_WORD_CNT_EN is defined.
interface serial_to_parallel_sync_if #(
  parameter int WIDTH = 8
`ifdef S2P_WORD_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
);
  logic             DATA_IN;
  logic [WIDTH-1:0] DATA_OUT;
  logic             VALID_OUT;
  logic             ACTIVE;
`ifdef S2P_WORD_CNT_EN
  logic [CNT_W-1:0] WORD_CNT;
`endif

  modport master (
    output DATA_IN,
    input  DATA_OUT,
    input  VALID_OUT,
    input  ACTIVE
`ifdef S2P_WORD_CNT_EN
    ,
    input  WORD_CNT
`endif
  );

  modport slave (
    input  DATA_IN,
    output DATA_OUT,
    output VALID_OUT,
    output ACTIVE
`ifdef S2P_WORD_CNT_EN
    ,
    output WORD_CNT
`endif
  );
endinterface

// File: rtl/serial_to_parallel_sync.sv
// Serial-to-parallel deserialiser, MSB first, with comma alignment and lock FSM.
// Optional word counter enabled by macro S2P_WORD_CNT_EN.
module serial_to_parallel_sync #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] COMMA       = 8'hBC,
  parameter int               LOCK_COMMAS = 4
`ifdef S2P_WORD_CNT_EN
  ,
  parameter int               CNT_W       = 16
`endif
) (
  input logic                   CLK,
  input logic                   RESET,
  serial_to_parallel_sync_if.slave s2p
);

  localparam int BC_W = $clog2(WIDTH);
  localparam int CC_W = $clog2(LOCK_COMMAS + 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_LOCKING,
    ST_ACTIVE
  } state_e;

  state_e            state_q;
  logic [WIDTH-2:0]  sreg_q;
  logic [BC_W-1:0]   bit_cnt_q;
  logic [CC_W-1:0]   comma_cnt_q;
  logic [WIDTH-1:0]  data_q;
  logic              valid_q;
  logic              active_q;
`ifdef S2P_WORD_CNT_EN
  logic [CNT_W-1:0]  word_cnt_q;
`endif

  logic [WIDTH-1:0]  nxt_d;
  logic [CC_W-1:0]   comma_cnt_d;
  logic              is_comma;
  logic              boundary;

  always_comb begin
    nxt_d       = {sreg_q, s2p.DATA_IN};
    // An X/Z bit makes the equality unknown, which the if() below treats as no match.
    is_comma    = (nxt_d == COMMA);
    boundary    = (bit_cnt_q == BC_W'(WIDTH - 1));
    comma_cnt_d = comma_cnt_q + CC_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_SEARCH;
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
`ifdef S2P_WORD_CNT_EN
      word_cnt_q  <= '0;
`endif
    end else begin
      sreg_q    <= nxt_d[WIDTH-2:0];
      valid_q   <= 1'b0;
      bit_cnt_q <= boundary ? '0 : bit_cnt_q + BC_W'(1);
      case (state_q)
        ST_SEARCH: begin
          // Bit-by-bit hunt: a match fixes the word boundary, so the counter restarts.
          if (is_comma) begin
            bit_cnt_q   <= '0;
            comma_cnt_q <= CC_W'(1);
            if (LOCK_COMMAS == 1) begin
              state_q  <= ST_ACTIVE;
              active_q <= 1'b1;
            end else begin
              state_q  <= ST_LOCKING;
            end
          end
        end
        ST_LOCKING: begin
          if (boundary) begin
            if (is_comma) begin
              comma_cnt_q <= comma_cnt_d;
              if (comma_cnt_d == CC_W'(LOCK_COMMAS)) begin
                state_q  <= ST_ACTIVE;
                active_q <= 1'b1;
              end
            end else begin
              state_q     <= ST_SEARCH;
              comma_cnt_q <= '0;
            end
          end
        end
        ST_ACTIVE: begin
          if (boundary) begin
            data_q  <= nxt_d;
            valid_q <= !is_comma;
`ifdef S2P_WORD_CNT_EN
            if (!is_comma) begin
              word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
`endif
          end
        end
        default: begin
          state_q <= ST_SEARCH;
        end
      endcase
    end
  end

  assign s2p.DATA_OUT  = data_q;
  assign s2p.VALID_OUT = valid_q;
  assign s2p.ACTIVE    = active_q;
`ifdef S2P_WORD_CNT_EN
  assign s2p.WORD_CNT  = word_cnt_q;
`endif

endmodule
